// File: rtl/pipe_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_if
//
// Bundles the signals exchanged between the pipeline stages and the central
// stall/flush scheduler.
//
//   stallreq_if  pipeline -> ctrl   icache miss, freezes stages 0..1
//   stallreq_id  pipeline -> ctrl   load-use hazard, freezes stages 0..2
//   stallreq_ex  pipeline -> ctrl   mul/div busy, freezes stages 0..3
//   stallreq_dc  pipeline -> ctrl   dcache miss, freezes stages 0..4
//   excp_valid   pipeline -> ctrl   redirect request (exception / ERET) pulse
//   excp_pc      pipeline -> ctrl   redirect target
//   stall        ctrl -> pipeline   stall bus, bit i holds stage i
//   flush        ctrl -> pipeline   kill all in-flight stages
//   new_pc       ctrl -> pipeline   redirect target, valid while flush = 1
//
// The "master" modport is the pipeline side; "slave" is the scheduler.
// ----------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_dc;
   logic        excp_valid;
   logic [31:0] excp_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;

   modport master (
      output stallreq_if,
      output stallreq_id,
      output stallreq_ex,
      output stallreq_dc,
      output excp_valid,
      output excp_pc,
      input  stall,
      input  flush,
      input  new_pc
   );

   modport slave (
      input  stallreq_if,
      input  stallreq_id,
      input  stallreq_ex,
      input  stallreq_dc,
      input  excp_valid,
      input  excp_pc,
      output stall,
      output flush,
      output new_pc
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush scheduler for the 6-stage pipeline
// (stage 0 PC, 1 IF, 2 ID, 3 EX, 4 DCACHE, 5 MEM).
//
//   clk           pipeline clock
//   rst           asynchronous, active-low reset
//   bus           stall requests / redirect in, stall bus / flush out
//   cnt_clr       synchronous clear of the stall-cycle counter
//   stall_cycles  saturating count of cycles with stall[0] = 1 in RUN
//   busy          high while a redirect is being sequenced
//
// Stall requests are merged combinationally into the stall bus. A redirect
// produces FLUSH_CYCLES cycles of registered flush/new_pc. If a dcache miss
// is outstanding when the redirect arrives, the target is parked and the
// pipeline is frozen (stages 0..4) until the miss resolves; the flush starts
// on the first cycle the miss is sampled low. Only the first redirect is
// honoured until the controller is back in RUN.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stall_ctrl_if.slave  bus,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic              busy
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FLUSH_WAIT = 2'd1,
      FLUSH      = 2'd2
   } state_t;

   // Final value of the flush counter before returning to RUN.
   localparam logic [2:0] LAST_FCNT = 3'(FLUSH_CYCLES - 1);

   state_t            state_reg,   state_next;
   logic [2:0]        fcnt_reg,    fcnt_next;
   logic [31:0]       pend_pc_reg, pend_pc_next;
   logic [31:0]       new_pc_reg,  new_pc_next;
   logic [CNT_W-1:0]  cnt_reg,     cnt_next;

   logic [3:0]        req_vec;
   logic [5:0]        run_stall;
   logic [5:0]        stall_comb;

   // ------------------------------------------------------------------------
   // Request merge. Request k (0=if .. 3=dc) freezes stages 0..k+1, so stage
   // gi is held by any request whose index is at least gi-1. Stages 0 and 1
   // are held by every request; MEM is never held.
   // ------------------------------------------------------------------------
   assign req_vec = {bus.stallreq_dc, bus.stallreq_ex,
                     bus.stallreq_id, bus.stallreq_if};

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_stall
         if (gi < 2) begin : g_all
            assign run_stall[gi] = |req_vec;
         end else begin : g_upper
            assign run_stall[gi] = |req_vec[3:gi-1];
         end
      end
   endgenerate

   assign run_stall[5] = 1'b0;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= RUN;
         fcnt_reg    <= 3'd0;
         pend_pc_reg <= 32'd0;
         new_pc_reg  <= 32'd0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         fcnt_reg    <= fcnt_next;
         pend_pc_reg <= pend_pc_next;
         new_pc_reg  <= new_pc_next;
         cnt_reg     <= cnt_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and stall bus
   // ------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      fcnt_next    = fcnt_reg;
      pend_pc_next = pend_pc_reg;
      new_pc_next  = new_pc_reg;
      stall_comb   = run_stall;

      case (state_reg)
         RUN: begin
            if (bus.excp_valid) begin
               pend_pc_next = bus.excp_pc;
               if (bus.stallreq_dc) begin
                  state_next = FLUSH_WAIT;
               end else begin
                  // new_pc is loaded on entry so it is valid in the first
                  // flush cycle.
                  state_next  = FLUSH;
                  new_pc_next = bus.excp_pc;
                  fcnt_next   = 3'd0;
               end
            end
         end

         FLUSH_WAIT: begin
            // Hold everything up to DCACHE while the miss drains, whatever
            // the other stages ask for.
            stall_comb = 6'b011111;
            if (!bus.stallreq_dc) begin
               state_next  = FLUSH;
               new_pc_next = pend_pc_reg;
               fcnt_next   = 3'd0;
            end
         end

         FLUSH: begin
            stall_comb = 6'b000000;
            if (fcnt_reg == LAST_FCNT) begin
               state_next = RUN;
               fcnt_next  = 3'd0;
            end else begin
               fcnt_next = fcnt_reg + 3'd1;
            end
         end

         default: begin
            state_next = RUN;
         end
      endcase

      // The stall bus must read idle for as long as reset is held, not just
      // after the next edge.
      if (!rst) begin
         stall_comb = 6'b000000;
      end
   end

   // ------------------------------------------------------------------------
   // Stall-cycle counter: counts RUN cycles with the PC stage held. Clear
   // beats increment; the count sticks at all-ones.
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_clr) begin
         cnt_next = '0;
      end else if ((state_reg == RUN) && run_stall[0] && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   assign bus.stall    = stall_comb;
   assign bus.flush    = (state_reg == FLUSH);
   assign bus.new_pc   = new_pc_reg;
   assign stall_cycles = cnt_reg;
   assign busy         = (state_reg != RUN);

endmodule
